ps2_rx_chk: RTL

Parametrised next-generation PS/2 device-to-host receiver.
- Deglitches ps2c and detects filtered falling edges.
- Shifts in a start / data / parity / stop frame, checks start, stop and odd parity, and aborts frames stalled by a lost clock.
- Sits between the PS/2 pins and the keypad/scan-code decoder in the elevator controller, feeding one byte per tick plus error status.

---
 rtl/ps2_rx_chk.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ps2_rx_chk.sv
// PS/2 device-to-host frame receiver: deglitches ps2c, shifts in start/data/parity/stop,
// reports parity and stop-bit status, and aborts frames whose clock goes missing.
module ps2_rx_chk #(
    parameter int FILTER_LEN  = 8,
    parameter int DATA_W      = 8,
    parameter int PARITY_EN   = 1,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2d,
    input  logic              ps2c,
    input  logic              rx_en,
    output logic [DATA_W-1:0] dout,
    output logic              rx_done_tick,
    output logic              parity_err,
    output logic              frame_err,
    output logic              timeout_tick,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int SH_W  = DATA_W + 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                fclk_q, fclk_d;
    logic                fall_edge;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [SH_W-1:0]     sh_q, sh_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                done_q, done_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                tmo_tick_q, tmo_tick_d;

    // History shifts toward the LSB; the newest ps2c sample enters at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < FILTER_LEN - 1; gi++) begin : g_hist
            assign filt_d[gi] = filt_q[gi+1];
        end
    endgenerate
    assign filt_d[FILTER_LEN-1] = ps2c;

    always_comb begin
        fclk_d = fclk_q;
        if (&filt_q)
            fclk_d = 1'b1;
        else if (~|filt_q)
            fclk_d = 1'b0;
    end

    assign fall_edge = fclk_q & ~|filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            filt_q     <= '0;
            fclk_q     <= 1'b0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            sh_q       <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            filt_q     <= filt_d;
            fclk_q     <= fclk_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            sh_q       <= sh_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            tmo_tick_q <= tmo_tick_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        sh_d       = sh_q;
        dout_d     = dout_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        done_d     = 1'b0;
        tmo_tick_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A high start bit is line noise and is dropped silently.
                if (fall_edge && rx_en && !ps2d) begin
                    state_d = DATA;
                    cnt_d   = CNT_LOAD;
                    tmo_d   = '0;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    sh_d  = {ps2d, sh_q[SH_W-1:1]};
                    tmo_d = '0;
                    if (cnt_q == '0)
                        state_d = CHECK;
                    else
                        cnt_d = cnt_q - CNT_W'(1);
                end else if (tmo_q == TMO_MAX) begin
                    tmo_tick_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CHECK: begin
                // sh_q holds {stop, parity, data[DATA_W-1:0]} once the stop bit is in.
                dout_d  = sh_q[DATA_W-1:0];
                perr_d  = (PARITY_EN != 0) & ~(^sh_q[DATA_W:0]);
                ferr_d  = ~sh_q[SH_W-1];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign timeout_tick = tmo_tick_q;
    assign busy         = (state_q != IDLE);

endmodule
